// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types.
//   lc3b_word      : 16-bit address / data word
//   lc3b_cacheline : 128-bit cache line moved between caches and physical memory
//   arb_state_t    : cache_arbiter FSM state
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of all request / response signals around the cache arbiter.
//   i_pmem_* : icache line-fill port (read only)
//   d_pmem_* : dcache fill / writeback port
//   pmem_*   : physical memory port
// Modports:
//   slave  : the arbiter itself (serves both caches, drives physical memory)
//   master : the surrounding system (caches issuing requests, memory answering)
interface cache_arbiter_if;
  import lc3b_types::*;

  logic          i_pmem_read;
  lc3b_word      i_pmem_address;
  logic          i_pmem_resp;
  lc3b_cacheline i_pmem_rdata;

  logic          d_pmem_read;
  logic          d_pmem_write;
  lc3b_word      d_pmem_address;
  lc3b_cacheline d_pmem_wdata;
  logic          d_pmem_resp;
  lc3b_cacheline d_pmem_rdata;

  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_cacheline pmem_wdata;
  logic          pmem_resp;
  lc3b_cacheline pmem_rdata;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_resp, i_pmem_rdata,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_resp, d_pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_resp, i_pmem_rdata,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_resp, d_pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );

endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates one physical memory port between the icache and the dcache.
// A granted transaction is latched (address, write data, direction) and
// presented to memory from those registers until pmem_resp; the requester's
// response is steered combinationally in the same cycle. A one-cycle RELEASE
// state follows every transaction so the served cache has dropped its request
// before arbitration runs again.
//
// Ports:
//   clk : system clock, all state on rising edge
//   rst : synchronous active-high reset (abandons any in-flight transaction)
//   bus : cache_arbiter_if.slave (icache, dcache and physical memory ports)
//
// Configuration:
//   CACHE_ARB_ROUND_ROBIN_EN defined   -> on simultaneous requests the side not
//                                         granted most recently wins
//   CACHE_ARB_ROUND_ROBIN_EN undefined -> dcache always wins ties
module cache_arbiter
  import lc3b_types::*;
(
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  arb_state_t    state;
  lc3b_word      addr_r;
  lc3b_cacheline wdata_r;
  logic          read_r;
  logic          write_r;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;

  assign i_req = bus.i_pmem_read;
  // Read and write together is handled as a writeback.
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // 1 = dcache was granted most recently. Reset value 0 lets the dcache win
  // the first tie.
  logic last_d_r;

  assign grant_d = d_req & (~i_req | ~last_d_r);
`else
  assign grant_d = d_req;
`endif
  assign grant_i = i_req & ~grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_r   <= '0;
      wdata_r  <= '0;
      read_r   <= 1'b0;
      write_r  <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_d_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= GRANT_D;
            addr_r  <= bus.d_pmem_address;
            wdata_r <= bus.d_pmem_wdata;
            read_r  <= ~bus.d_pmem_write;
            write_r <= bus.d_pmem_write;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_d_r <= 1'b1;
`endif
          end else if (grant_i) begin
            state   <= GRANT_I;
            addr_r  <= bus.i_pmem_address;
            wdata_r <= '0;
            read_r  <= 1'b1;
            write_r <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_d_r <= 1'b0;
`endif
          end
        end
        GRANT_I, GRANT_D: begin
          if (bus.pmem_resp) begin
            state   <= RELEASE;
            read_r  <= 1'b0;
            write_r <= 1'b0;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory sees only the latched copy, so requester changes mid-grant are invisible.
  assign bus.pmem_read    = read_r;
  assign bus.pmem_write   = write_r;
  assign bus.pmem_address = addr_r;
  assign bus.pmem_wdata   = wdata_r;

  // Only the response strobe is steered; a pmem_resp outside a grant goes nowhere.
  assign bus.i_pmem_resp  = (state == GRANT_I) & bus.pmem_resp;
  assign bus.d_pmem_resp  = (state == GRANT_D) & bus.pmem_resp;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous active-high reset.
REQ-003 SHALL have: i_pmem_read  in  1  icache line-fill request.
REQ-004 SHALL have: i_pmem_address  in  lc3b_word  icache line address.
REQ-005 SHALL have: i_pmem_resp  out  1  icache transaction done.
REQ-006 SHALL have: i_pmem_rdata  out  lc3b_cacheline  icache fill data.
REQ-007 SHALL have: d_pmem_read  in  1 and d_pmem_write  in  1  dcache fill / writeback requests.
REQ-008 SHALL have: d_pmem_address  in  lc3b_word and d_pmem_wdata  in  lc3b_cacheline  dcache address / writeback line.
REQ-009 SHALL have: d_pmem_resp  out  1 and d_pmem_rdata  out  lc3b_cacheline  dcache done / fill data.
REQ-010 SHALL have: pmem_read  out  1, pmem_write  out  1, pmem_address  out  lc3b_word, pmem_wdata  out  lc3b_cacheline  physical memory request.
REQ-011 SHALL have: pmem_resp  in  1 and pmem_rdata  in  lc3b_cacheline  physical memory response.
REQ-012 One clock (clk); reset rst is synchronous and active-high.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, RELEASE.
REQ-014 IDLE: any request seen at edge N -> grant state at N+1; no request -> stay IDLE.
REQ-015 Simultaneous i and d requests in IDLE: dcache granted (fixed priority) unless REQ-028 applies.
REQ-016 On grant, SHALL latch address, wdata, and direction (read/write) into registers; pmem_* driven only from these registers.
REQ-017 GRANT_x: pmem_read or pmem_write asserted (exactly one) every cycle until pmem_resp; requester input changes during grant ignored.
REQ-018 Cycle with pmem_resp=1 in GRANT_x: x_pmem_resp=1 combinationally that cycle, x_pmem_rdata = pmem_rdata; other side's resp stays 0.
REQ-019 After pmem_resp: next state RELEASE for exactly one cycle, pmem_read=pmem_write=0, no grant; then IDLE.
REQ-020 RELEASE guarantees a requester that just received resp has deasserted before re-arbitration; no duplicate transaction.
REQ-021 i_pmem_rdata/d_pmem_rdata SHALL equal pmem_rdata at all times (pass-through); only resp is steered.
REQ-022 pmem_resp outside GRANT_x SHALL be ignored (no resp forwarded, no state change).
REQ-023 d_pmem_read and d_pmem_write both high: treated as write.
REQ-024 Best-case latency request->first pmem assertion: 1 cycle; back-to-back transactions separated by RELEASE + IDLE (2 idle pmem cycles).

Reset
REQ-025 rst=1 at edge: state IDLE, all latched registers 0, priority pointer to dcache; in-flight transaction abandoned.
REQ-026 Outputs during and after reset until next grant: pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, i_pmem_resp=0, d_pmem_resp=0.
REQ-027 pmem_resp arriving after reset for an abandoned transaction SHALL be ignored per REQ-022.

Configuration
REQ-028 Macro CACHE_ARB_ROUND_ROBIN_EN defined: 1-bit last-grant register; on simultaneous requests the side not granted most recently wins; single requester always granted.
REQ-029 Macro undefined: fixed dcache priority per REQ-015; no last-grant register.

Structure
REQ-030 lc3b_word, lc3b_cacheline (128 bits) from lc3b_types; arbiter state enum added to lc3b_types as arb_state_t.
REQ-031 Single flat module; no sub-module.

Verification
REQ-032 i read only, addr 0x1230, pmem_resp after 3 cycles with data 0xA5..A5 -> pmem_read at N+1 with addr 0x1230, i_pmem_resp one cycle with that data, d_pmem_resp 0.
REQ-033 i read 0x1000 and d write 0x2000 same cycle, fixed priority -> pmem_write addr 0x2000 first; after resp+RELEASE, pmem_read addr 0x1000.
REQ-034 Same as REQ-033 with CACHE_ARB_ROUND_ROBIN_EN, repeated twice with both held -> grants alternate D,I,D,I.
REQ-035 d_pmem_address changed 0x2000->0x3000 mid-grant -> pmem_address stays 0x2000 until resp.
REQ-036 rst asserted during GRANT_D, then stale pmem_resp -> pmem_read/write 0 next cycle, no d_pmem_resp, state IDLE.
REQ-037 pmem_resp pulsed in IDLE -> no resp outputs, state unchanged.
